layer1_asm_array: RTL and testbench

- Parametrised array of CH_NUM binary-neuron accumulate/threshold units for layer 1.
- A pixel stream is shared by all channels. Each channel adds or subtracts each pixel according to its 1-bit weight, over a window of TAPS pixels.
- At the end of the window each channel compares its sum with its own batch-norm threshold. The result is a CH_NUM-bit binary activation word.
- Adds a valid/ready handshake, per-channel threshold registers, window counting and an abort input. Sits between the pixel/weight fetch logic and the layer-1 output buffer.

---
 rtl/layer1_asm_array.sv | 156 +++++++++++++++
 tb/tb_layer1_asm_array.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer1_asm_array.sv
// Layer-1 binary-neuron array: CH_NUM channels add/subtract a shared pixel stream over TAPS-beat windows, then threshold.
// Optional macro LAYER1_ASM_SAT_EN: saturating accumulators instead of two's-complement wraparound.
module layer1_asm_array #(
  parameter int IMG_WIDTH = 16,
  parameter int BN_WIDTH  = 16,
  parameter int CH_NUM    = 8,
  parameter int TAPS      = 9,
  parameter int ACC_WIDTH = 24,
  localparam int ADDR_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int TAP_W    = $clog2(TAPS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        calculate_en,
  input  logic                        abort,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IMG_WIDTH-1:0] data_pix,
  input  logic        [CH_NUM-1:0]    data_weight,
  input  logic                        bn_we,
  input  logic        [ADDR_W-1:0]    bn_addr,
  input  logic signed [BN_WIDTH-1:0]  bn_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic        [CH_NUM-1:0]    data_out,
  output logic        [TAP_W-1:0]     tap_cnt
);

  typedef enum logic [1:0] {ACCUM, CMP, OUT} state_t;

  state_t state, state_nxt;

  logic signed [ACC_WIDTH-1:0] acc_p0 [CH_NUM];
  logic signed [BN_WIDTH-1:0]  thr_p0 [CH_NUM];
  logic        [CH_NUM-1:0]    cmp_word;

  logic accept;
  logic last_beat;
  logic out_hs;
  logic clr_win;

`ifdef LAYER1_ASM_SAT_EN
  localparam int EXT_W = ACC_WIDTH + 2;

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [EXT_W-1:0] s);
    logic signed [EXT_W-1:0] lim_hi;
    logic signed [EXT_W-1:0] lim_lo;
    lim_hi = {3'b000, {(ACC_WIDTH-1){1'b1}}};
    lim_lo = {3'b111, {(ACC_WIDTH-1){1'b0}}};
    if (s > lim_hi)
      return lim_hi[ACC_WIDTH-1:0];
    else if (s < lim_lo)
      return lim_lo[ACC_WIDTH-1:0];
    else
      return s[ACC_WIDTH-1:0];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] acc_step(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic signed [IMG_WIDTH-1:0] pix,
    input logic                        w
  );
    logic signed [EXT_W-1:0] term;
    logic signed [EXT_W-1:0] sum;
    term = EXT_W'(pix);
    sum  = w ? (EXT_W'(acc) + term) : (EXT_W'(acc) - term);
    return sat_acc(sum);
  endfunction
`else
  function automatic logic signed [ACC_WIDTH-1:0] acc_step(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic signed [IMG_WIDTH-1:0] pix,
    input logic                        w
  );
    logic signed [ACC_WIDTH-1:0] term;
    term = ACC_WIDTH'(pix);
    return w ? (acc + term) : (acc - term);
  endfunction
`endif

  function automatic logic thr_pass(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic signed [BN_WIDTH-1:0]  thr
  );
    return acc >= ACC_WIDTH'(thr);
  endfunction

  assign in_ready  = (state == ACCUM) & calculate_en & ~abort;
  assign accept    = in_valid & in_ready;
  assign last_beat = accept & (tap_cnt == TAP_W'(TAPS - 1));
  assign out_hs    = (state == OUT) & out_ready;
  assign clr_win   = abort | out_hs;
  assign out_valid = (state == OUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ACCUM;
    else
      state <= state_nxt;
  end

  // abort wins over both beat acceptance and the output handshake
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (last_beat) state_nxt = CMP;
        CMP:     state_nxt = OUT;
        OUT:     if (out_ready) state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // stage p0: window accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_cnt <= '0;
      for (int k = 0; k < CH_NUM; k++) acc_p0[k] <= '0;
    end else if (clr_win) begin
      tap_cnt <= '0;
      for (int k = 0; k < CH_NUM; k++) acc_p0[k] <= '0;
    end else if (accept) begin
      tap_cnt <= tap_cnt + TAP_W'(1);
      for (int k = 0; k < CH_NUM; k++)
        acc_p0[k] <= acc_step(acc_p0[k], data_pix, data_weight[k]);
    end
  end

  // Out-of-range addresses match no channel and are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CH_NUM; k++) thr_p0[k] <= '0;
    end else if (bn_we) begin
      for (int k = 0; k < CH_NUM; k++)
        if (ADDR_W'(k) == bn_addr) thr_p0[k] <= bn_data;
    end
  end

  always_comb begin
    cmp_word = '0;
    for (int k = 0; k < CH_NUM; k++)
      cmp_word[k] = thr_pass(acc_p0[k], thr_p0[k]);
  end

  // stage p1: thresholded result; a write landing on the CMP edge only reaches the next window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      data_out <= '0;
    else if ((state == CMP) && !abort)
      data_out <= cmp_word;
  end

endmodule

// File: tb/tb_layer1_asm_array.sv
// Bench for layer1_asm_array: directed table, multi-cycle corner sequences and a randomized run vs a window-level model.
module tb_layer1_asm_array;
  localparam int CH      = 8;
  localparam int TAPS    = 9;
  localparam int ACC_W   = 24;
  localparam int ACC_W_S = 17;

  logic clk = 1'b0;
  logic rst, calculate_en, abort, in_valid, out_ready, bn_we;
  logic signed [15:0] data_pix, bn_data;
  logic [7:0] data_weight;
  logic [2:0] bn_addr;
  logic in_ready, out_valid, in_ready_s, out_valid_s;
  logic [7:0] data_out, data_out_s;
  logic [3:0] tap_cnt, tap_cnt_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  layer1_asm_array u_dut (
    .clk(clk), .rst(rst), .calculate_en(calculate_en), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .data_pix(data_pix), .data_weight(data_weight),
    .bn_we(bn_we), .bn_addr(bn_addr), .bn_data(bn_data),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .tap_cnt(tap_cnt)
  );

  layer1_asm_array #(.ACC_WIDTH(ACC_W_S)) u_sat (
    .clk(clk), .rst(rst), .calculate_en(calculate_en), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_s), .data_pix(data_pix), .data_weight(data_weight),
    .bn_we(bn_we), .bn_addr(bn_addr), .bn_data(bn_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .data_out(data_out_s), .tap_cnt(tap_cnt_s)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  // ---------------- window-level reference model ----------------
  typedef struct { logic signed [15:0] pix; logic [7:0] wt; } beat_t;
  beat_t beat_q[$];
  int    thr_m [CH];
  bit    m_due, m_present;
  logic [7:0] m_out;

  function automatic longint wrap_to(input longint s, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = ((s % m) + m) % m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic logic [7:0] window_result();
    logic [7:0] r;
    longint s;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      s = 0;
      foreach (beat_q[i]) s += beat_q[i].wt[k] ? longint'(beat_q[i].pix) : -longint'(beat_q[i].pix);
      r[k] = (wrap_to(s, ACC_W) >= longint'(thr_m[k]));
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        beat_q.delete();
        m_due = 0; m_present = 0; m_out = '0;
        for (int k = 0; k < CH; k++) thr_m[k] = 0;
      end else begin
        if (abort) begin
          beat_q.delete(); m_due = 0; m_present = 0;
        end else if (m_present) begin
          if (out_ready) begin m_present = 0; beat_q.delete(); end
        end else if (m_due) begin
          m_out = window_result(); m_due = 0; m_present = 1;
        end else if (calculate_en && in_valid) begin
          beat_q.push_back('{data_pix, data_weight});
          if (beat_q.size() == TAPS) m_due = 1;
        end
        if (bn_we && int'(bn_addr) < CH) thr_m[bn_addr] = int'(bn_data);
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_due && !m_present && calculate_en && !abort);
    chk("out_valid", out_valid, m_present);
    chk("data_out", data_out, m_out);
    chk("tap_cnt", tap_cnt, beat_q.size());
    chk("in_ready_s", in_ready_s, in_ready);
    chk("tap_cnt_s", tap_cnt_s, tap_cnt);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic signed [15:0] pix, input logic [7:0] wt);
    logic ok;
    data_pix = pix; data_weight = wt; in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #1 ok = in_ready;
      tick();
      if (ok) begin in_valid = 1'b0; return; end
    end
    in_valid = 1'b0;
    n_err++;
    $display("FAIL send_beat: beat not accepted within 40 cycles at %0t", $time);
  endtask

  task automatic write_thr(input logic signed [15:0] lo, input logic signed [15:0] hi);
    for (int k = 0; k < CH; k++) begin
      bn_we = 1'b1; bn_addr = 3'(k); bn_data = (k < 4) ? lo : hi;
      tick();
    end
    bn_we = 1'b0;
  endtask

  // Called right after the final beat's edge; checks latency, optional stall, handshake
  task automatic finish_window(input int hold, output logic [7:0] res, output logic [7:0] res_s);
    logic [7:0] d0;
    chk("lat_cmp_vld", out_valid, 0);
    tick();
    chk("lat_out_vld", out_valid, 1);
    chk("out_vld_s", out_valid_s, 1);
    d0 = data_out;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      tick();
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_vld", out_valid, 1);
      chk("hold_data", data_out, d0);
    end
    in_valid = 1'b0;
    res = data_out; res_s = data_out_s;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("hs_out_vld", out_valid, 0);
    chk("hs_tap_cnt", tap_cnt, 0);
  endtask

  task automatic run_window(input logic signed [15:0] pix, input logic [7:0] wt, input int hold,
                            output logic [7:0] res, output logic [7:0] res_s);
    for (int i = 0; i < TAPS; i++) send_beat(pix, wt);
    finish_window(hold, res, res_s);
  endtask

  logic signed [15:0] plist [TAPS];
  logic [7:0]         wlist [TAPS];

  task automatic run_list(input int pause_at, output logic [7:0] res);
    logic [7:0] rs;
    for (int i = 0; i < TAPS; i++) begin
      if (i == pause_at) begin
        calculate_en = 1'b0;
        repeat (3) tick();
        chk("pause_tap_cnt", tap_cnt, pause_at);
        calculate_en = 1'b1;
      end
      send_beat(plist[i], wlist[i]);
    end
    finish_window(0, res, rs);
  endtask

  function automatic logic [7:0] list_expect();
    logic [7:0] r;
    int s;
    for (int k = 0; k < CH; k++) begin
      s = 0;
      for (int i = 0; i < TAPS; i++) s += wlist[i][k] ? int'(plist[i]) : -int'(plist[i]);
      r[k] = (s >= 0);
    end
    return r;
  endfunction

  typedef struct {
    logic signed [15:0] pix;
    logic [7:0]         wt;
    logic signed [15:0] thr_lo;
    logic signed [15:0] thr_hi;
    logic [7:0]         exp;
  } vec_t;
  vec_t tbl [7];

  initial begin
    logic [7:0] r1, r2, rs;
    longint s_wrap, s_sat;
    logic [7:0] exp_s;

    tbl[0] = '{16'sd5,      8'hAA, 16'sd0,     16'sd0,      8'hAA};
    tbl[1] = '{16'sd5,      8'hFF, 16'sd45,    16'sd46,     8'h0F};
    tbl[2] = '{-16'sd5,     8'hFF, -16'sd45,   -16'sd44,    8'h0F};
    tbl[3] = '{-16'sd5,     8'h00, 16'sd45,    16'sd46,     8'h0F};
    tbl[4] = '{16'sd32767,  8'hF0, 16'sd32767, 16'sh8000,   8'hF0};
    tbl[5] = '{16'sh8000,   8'h3C, 16'sd0,     16'sd0,      8'hC3};
    tbl[6] = '{16'sd0,      8'h5A, 16'sd0,     16'sd1,      8'h0F};
    plist = '{16'sd3, -16'sd7, 16'sd11, 16'sd2, -16'sd1, 16'sd8, -16'sd4, 16'sd6, 16'sd5};
    wlist = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h99, 8'h66, 8'h81, 8'h7E, 8'h3C};

    rst = 1'b0; calculate_en = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bn_we = 1'b0; bn_addr = '0; bn_data = '0; data_pix = '0; data_weight = '0;
    repeat (3) tick();
    chk("rst_out_vld", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_tap_cnt", tap_cnt, 0);
    rst = 1'b1; calculate_en = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      write_thr(tbl[i].thr_lo, tbl[i].thr_hi);
      run_window(tbl[i].pix, tbl[i].wt, (i == 0) ? 5 : 0, r1, rs);
      chk($sformatf("tbl%0d", i), r1, tbl[i].exp);
    end

    // pause mid-window must match an uninterrupted window
    write_thr(16'sd0, 16'sd0);
    run_list(-1, r1);
    chk("list_plain", r1, list_expect());
    run_list(4, r2);
    chk("list_paused", r2, r1);

    // abort after 4 beats, then a clean window
    for (int i = 0; i < 4; i++) send_beat(16'sd5, 8'hFF);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_tap_cnt", tap_cnt, 0);
    chk("abort_data_kept", data_out, r2);
    run_window(16'sd5, 8'hAA, 0, r1, rs);
    chk("post_abort", r1, 8'hAA);

    // abort while presenting beats the handshake and keeps data_out
    for (int i = 0; i < TAPS; i++) send_beat(16'sd5, 8'h0F);
    tick();
    chk("pre_abort_out", data_out, 8'h0F);
    abort = 1'b1; out_ready = 1'b1; tick(); abort = 1'b0; out_ready = 1'b0;
    chk("abort_out_vld", out_valid, 0);
    chk("abort_out_data", data_out, 8'h0F);

    // threshold write on the CMP edge only reaches the next window
    for (int i = 0; i < TAPS; i++) send_beat(16'sd5, 8'hFF);
    bn_we = 1'b1; bn_addr = 3'd2; bn_data = 16'sd1000;
    tick();
    bn_we = 1'b0;
    chk("cmpwr_vld", out_valid, 1);
    chk("cmpwr_old_thr", data_out, 8'hFF);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    run_window(16'sd5, 8'hFF, 0, r1, rs);
    chk("cmpwr_new_thr", r1, 8'hFB);

    // narrow accumulator: wrap vs saturate
    write_thr(16'sd32760, 16'sd32760);
    run_window(16'sd32767, 8'hFF, 0, r1, rs);
    chk("wide_acc", r1, 8'hFF);
    s_wrap = wrap_to(longint'(TAPS) * 32767, ACC_W_S);
    s_sat  = (longint'(TAPS) * 32767 > 65535) ? 65535 : longint'(TAPS) * 32767;
`ifdef LAYER1_ASM_SAT_EN
    exp_s = (s_sat >= 32760) ? 8'hFF : 8'h00;
`else
    exp_s = (s_wrap >= 32760) ? 8'hFF : 8'h00;
`endif
    chk("narrow_acc", rs, exp_s);

    // asynchronous reset mid-window
    for (int i = 0; i < 3; i++) send_beat(16'sd7, 8'h33);
    #2 rst = 1'b0;
    #1;
    chk("arst_tap_cnt", tap_cnt, 0);
    chk("arst_data_out", data_out, 0);
    #2 rst = 1'b1;
    tick();

    for (int c = 0; c < 4000; c++) begin
      calculate_en = ($urandom_range(0, 9) != 0);
      in_valid     = ($urandom_range(0, 9) < 7);
      abort        = ($urandom_range(0, 49) == 0);
      out_ready    = ($urandom_range(0, 1) == 1);
      data_pix     = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) - 16'sd10 : 16'($urandom);
      data_weight  = 8'($urandom);
      bn_we        = ($urandom_range(0, 7) == 0);
      bn_addr      = 3'($urandom);
      bn_data      = 16'($urandom_range(0, 120)) - 16'sd60;
      tick();
    end
    calculate_en = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; bn_we = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
